// File: rtl/i2c_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_cmd_arbiter
//
// Shares one i2c_dri engine between two command sources:
//   port 0 : WM8978 power-up register sequencer (i2c_reg_cfg)
//   port 1 : runtime control path (volume/mute writes, status reads)
//
// One transaction is in flight at a time. The winning request's fields are
// latched on grant, a single-cycle i2c_exec is issued, and the arbiter waits
// for i2c_done (or a timeout). The result is then returned to the granted
// port with a one-cycle done pulse.
//
// Configuration macro:
//   I2C_ARB_RR_EN  defined   -> round-robin between simultaneous requests
//                  undefined -> fixed priority, port 0 always wins
//
// Parameters:
//   TIMEOUT_CYC  clk cycles allowed between i2c_exec and i2c_done
//   ADDR_W       width of the I2C word-address field
//
// Ports (clk domain = i2c_dri dri_clk, synchronous active-high rst):
//   req/addr/wdata/rh_wl/bit_ctrl 0,1  request inputs, req held until done
//   done/rdata/err 0,1                 per-port response, rdata/err hold
//   i2c_exec, i2c_addr, i2c_data_w,
//   i2c_rh_wl, i2c_bit_ctrl            command to i2c_dri
//   i2c_data_r, i2c_done               response from i2c_dri
//   busy                               high whenever not idle
//   grant                              index of current/last granted port
// ---------------------------------------------------------------------------
module i2c_cmd_arbiter #(
  parameter logic [19:0] TIMEOUT_CYC = 20'd100_000,
  parameter int          ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  // port 0
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [7:0]        wdata0,
  input  logic              rh_wl0,
  input  logic              bit_ctrl0,
  output logic              done0,
  output logic [7:0]        rdata0,
  output logic              err0,
  // port 1
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        wdata1,
  input  logic              rh_wl1,
  input  logic              bit_ctrl1,
  output logic              done1,
  output logic [7:0]        rdata1,
  output logic              err1,
  // i2c_dri side
  output logic              i2c_exec,
  output logic [ADDR_W-1:0] i2c_addr,
  output logic [7:0]        i2c_data_w,
  output logic              i2c_rh_wl,
  output logic              i2c_bit_ctrl,
  input  logic [7:0]        i2c_data_r,
  input  logic              i2c_done,
  // status
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [19:0] tmo_cnt;
  logic        tmo_hit;
  logic        any_req;
  logic        win;

  assign any_req = req0 | req1;
  assign tmo_hit = (tmo_cnt == (TIMEOUT_CYC - 20'd1));

  // -------------------------------------------------------------------------
  // Winner selection. Only meaningful when any_req is high.
  // -------------------------------------------------------------------------
`ifdef I2C_ARB_RR_EN
  // Port that is preferred on a tie: the one not granted last.
  logic rr_ptr;

  always_comb begin
    if (req0 && req1) win = rr_ptr;
    else              win = req1;
  end

  always_ff @(posedge clk) begin
    if (rst)                          rr_ptr <= 1'b0;
    else if (state == IDLE && any_req) rr_ptr <= ~win;
  end
`else
  // Fixed priority: port 1 only wins when port 0 is idle, so the power-up
  // sequence always completes before runtime traffic.
  always_comb begin
    win = ~req0;
  end
`endif

  // -------------------------------------------------------------------------
  // FSM next-state and decoded outputs.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    i2c_exec  = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        i2c_exec  = 1'b1;
        state_nxt = WAIT;
      end
      // i2c_done takes precedence over a timeout in the same cycle.
      WAIT:  if (i2c_done || tmo_hit) state_nxt = RESP;
      RESP: begin
        done0     = ~grant;
        done1     = grant;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, latched command fields, timeout counter and response registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      grant        <= 1'b0;
      i2c_addr     <= '0;
      i2c_data_w   <= '0;
      i2c_rh_wl    <= 1'b0;
      i2c_bit_ctrl <= 1'b0;
      rdata0       <= '0;
      err0         <= 1'b0;
      rdata1       <= '0;
      err1         <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // Fields are captured once here; later requester changes are ignored.
          if (any_req) begin
            grant        <= win;
            i2c_addr     <= win ? addr1     : addr0;
            i2c_data_w   <= win ? wdata1    : wdata0;
            i2c_rh_wl    <= win ? rh_wl1    : rh_wl0;
            i2c_bit_ctrl <= win ? bit_ctrl1 : bit_ctrl0;
          end
        end
        ISSUE: tmo_cnt <= '0;
        WAIT: begin
          tmo_cnt <= tmo_cnt + 20'd1;
          if (i2c_done) begin
            if (grant) begin
              rdata1 <= i2c_data_r;
              err1   <= 1'b0;
            end else begin
              rdata0 <= i2c_data_r;
              err0   <= 1'b0;
            end
          end else if (tmo_hit) begin
            if (grant) begin
              rdata1 <= 8'h00;
              err1   <= 1'b1;
            end else begin
              rdata0 <= 8'h00;
              err0   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_cmd_arbiter
//
// Self-checking bench for i2c_cmd_arbiter (TIMEOUT_CYC overridden to 64).
// A transaction-level reference model tracks grant/exec/response times as
// cycle stamps; a compare process checks every DUT output against it on each
// falling edge. Directed scenarios pin the model with literal expectations,
// then a randomized phase drives both requesters and a random i2c_dri model.
// Build with +define+I2C_ARB_RR_EN to select round-robin expectations.
// ---------------------------------------------------------------------------
module tb_i2c_cmd_arbiter;

  localparam int          AW     = 16;
  localparam logic [19:0] TO_CYC = 20'd64;
  localparam int          TO     = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [7:0]    wdata0, wdata1;
  logic          rh_wl0, rh_wl1, bit_ctrl0, bit_ctrl1;
  logic          done0, done1, err0, err1;
  logic [7:0]    rdata0, rdata1;
  logic          i2c_exec, i2c_rh_wl, i2c_bit_ctrl, i2c_done;
  logic [AW-1:0] i2c_addr;
  logic [7:0]    i2c_data_w, i2c_data_r;
  logic          busy, grant;

  always #5 clk = ~clk;

  i2c_cmd_arbiter #(.TIMEOUT_CYC(TO_CYC), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .rh_wl0(rh_wl0),
    .bit_ctrl0(bit_ctrl0), .done0(done0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .rh_wl1(rh_wl1),
    .bit_ctrl1(bit_ctrl1), .done1(done1), .rdata1(rdata1), .err1(err1),
    .i2c_exec(i2c_exec), .i2c_addr(i2c_addr), .i2c_data_w(i2c_data_w),
    .i2c_rh_wl(i2c_rh_wl), .i2c_bit_ctrl(i2c_bit_ctrl),
    .i2c_data_r(i2c_data_r), .i2c_done(i2c_done),
    .busy(busy), .grant(grant)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: one transaction at a time, described by cycle stamps.
  // cyc is the number of the cycle that starts at the latest rising edge.
  // -------------------------------------------------------------------------
  int            cyc = 0;
  bit            m_act = 0;
  int            m_exec = -10;
  int            m_resp = -10;
  bit            m_port = 0;
  bit            m_grant = 0;
  bit            m_pref = 0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_wd = '0;
  bit            m_rw = 0, m_bc = 0;
  logic [7:0]    m_rd [2];
  bit            m_err [2];

  initial begin : model
    m_rd[0] = '0; m_rd[1] = '0; m_err[0] = 0; m_err[1] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_act = 0; m_port = 0; m_grant = 0; m_pref = 0;
        m_addr = '0; m_wd = '0; m_rw = 0; m_bc = 0;
        m_rd[0] = '0; m_rd[1] = '0; m_err[0] = 0; m_err[1] = 0;
        m_exec = -10; m_resp = -10;
      end else if (!m_act) begin
        if (req0 || req1) begin
`ifdef I2C_ARB_RR_EN
          m_port = (req0 && req1) ? m_pref : req1;
`else
          m_port = !req0;
`endif
          m_pref  = !m_port;
          m_grant = m_port;
          m_addr  = m_port ? addr1     : addr0;
          m_wd    = m_port ? wdata1    : wdata0;
          m_rw    = m_port ? rh_wl1    : rh_wl0;
          m_bc    = m_port ? bit_ctrl1 : bit_ctrl0;
          m_act   = 1;
          m_exec  = cyc;      // exec is issued in the cycle right after grant
          m_resp  = -1;
        end
      end else if (m_resp == cyc - 1) begin
        m_act = 0;            // one idle cycle follows every response
      end else if (m_resp < 0 && cyc - 1 > m_exec) begin
        // previous cycle was a waiting cycle
        if (i2c_done) begin
          m_resp = cyc;
          m_rd[m_port]  = i2c_data_r;
          m_err[m_port] = 0;
        end else if (cyc - 1 == m_exec + TO) begin
          m_resp = cyc;
          m_rd[m_port]  = 8'h00;
          m_err[m_port] = 1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Compare process: every output, every cycle, sampled on the falling edge.
  // -------------------------------------------------------------------------
  bit seen_exec = 0;

  initial begin : compare
    forever begin
      @(negedge clk);
      seen_exec = i2c_exec;
      if (cyc > 0) begin
        check("exec",   i2c_exec, (m_act && cyc == m_exec));
        check("busy",   busy,     m_act);
        check("done0",  done0,    (m_act && cyc == m_resp && m_port == 0));
        check("done1",  done1,    (m_act && cyc == m_resp && m_port == 1));
        check("grant",  grant,    m_grant);
        check("fields", {i2c_addr, i2c_data_w, i2c_rh_wl, i2c_bit_ctrl},
                        {m_addr, m_wd, m_rw, m_bc});
        check("resp0",  {rdata0, err0}, {m_rd[0], m_err[0]});
        check("resp1",  {rdata1, err1}, {m_rd[1], m_err[1]});
      end
    end
  end

  // -------------------------------------------------------------------------
  // i2c_dri stand-in: answers slave_dly cycles after exec (0 = never).
  // It deliberately ignores reset so a late done can land in idle.
  // -------------------------------------------------------------------------
  int         slave_dly = 1;
  bit         slave_rand = 0;
  bit         slave_fix_en = 0;
  logic [7:0] slave_fix = '0;
  int         s_target = -1;
  logic [7:0] s_data = '0;

  initial begin : slave
    int d;
    i2c_done = 1'b0;
    i2c_data_r = '0;
    forever begin
      @(posedge clk);
      #1;
      if (seen_exec) begin
        d = slave_dly;
        if (slave_rand) d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
        s_target = (d == 0) ? -1 : cyc - 1 + d;
        s_data = slave_fix_en ? slave_fix : 8'($urandom);
      end
      i2c_done   = (s_target >= 0 && cyc == s_target);
      i2c_data_r = i2c_done ? s_data : 8'($urandom);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_exec(input int budget, output int lat);
    lat = 0;
    for (int i = 1; i <= budget && lat == 0; i++) begin
      @(negedge clk);
      if (i2c_exec === 1'b1) lat = i;
    end
  endtask

  task automatic wait_done(input bit port, input int budget, output int lat);
    lat = 0;
    for (int i = 1; i <= budget && lat == 0; i++) begin
      @(negedge clk);
      if ((port ? done1 : done0) === 1'b1) lat = i;
    end
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  int order [6];
  int exp_order [6];
  int lat, n, c0, c1;
  bit stable, got, bad, d0, d1;

  initial begin : main
`ifdef I2C_ARB_RR_EN
    exp_order = '{0, 1, 0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 1, 1, 1};
`endif
    rst = 1'b1;
    req0 = 0; addr0 = '0; wdata0 = '0; rh_wl0 = 0; bit_ctrl0 = 0;
    req1 = 0; addr1 = '0; wdata1 = '0; rh_wl1 = 0; bit_ctrl1 = 0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {i2c_exec, busy, grant, done0, done1, err0, err1}, 0);
    check("reset_addr", i2c_addr, 0);

    // 1: single write, i2c_done 40 cycles after exec
    slave_dly = 40;
    step();
    req0 = 1; addr0 = 16'h000B; wdata0 = 8'hFF; rh_wl0 = 0; bit_ctrl0 = 0;
    wait_exec(5, lat);
    check("t1_exec_latency", lat, 2);
    check("t1_i2c_addr", i2c_addr, 16'h000B);
    check("t1_i2c_data_w", i2c_data_w, 8'hFF);
    check("t1_i2c_rh_wl", i2c_rh_wl, 0);
    wait_done(0, 100, lat);
    check("t1_done_latency", lat, 41);
    check("t1_err0", err0, 0);
    step();
    req0 = 0;
    @(negedge clk);
    check("t1_busy_low", busy, 0);

    // 2: read on port 1 returning 8'h5A
    slave_dly = 6; slave_fix_en = 1; slave_fix = 8'h5A;
    step();
    req1 = 1; rh_wl1 = 1; addr1 = 16'h0034; wdata1 = 8'h00; bit_ctrl1 = 1;
    wait_exec(5, lat);
    check("t2_exec_latency", lat, 2);
    check("t2_i2c_addr", i2c_addr, 16'h0034);
    check("t2_grant", grant, 1);
    wait_done(1, 50, lat);
    check("t2_done_latency", lat, 7);
    check("t2_rdata1", rdata1, 8'h5A);
    check("t2_err1", err1, 0);
    check("t2_done0_quiet", done0, 0);
    step();
    req1 = 0; slave_fix_en = 0;

    // 3: contention, three transactions per port
    slave_rand = 1;
    n = 0; c0 = 0; c1 = 0;
    step();
    req0 = 1; addr0 = 16'h1100; wdata0 = 8'h11;
    req1 = 1; addr1 = 16'h2200; wdata1 = 8'h22;
    for (int i = 0; i < 2000 && (c0 < 3 || c1 < 3); i++) begin
      @(negedge clk);
      if (i2c_exec && n < 6) begin
        order[n] = int'(grant);
        n++;
      end
      if (done0) c0++;
      if (done1) c1++;
      step();
      if (c0 >= 3) req0 = 0;
      if (c1 >= 3) req1 = 0;
    end
    check("t3_exec_count", n, 6);
    for (int k = 0; k < 6; k++) check($sformatf("t3_grant_%0d", k), order[k], exp_order[k]);
    slave_rand = 0;

    // 4: timeout then a normal port-1 transaction
    slave_dly = 0;
    step();
    req0 = 1; addr0 = 16'h0101; rh_wl0 = 1;
    wait_exec(5, lat);
    check("t4_exec_latency", lat, 2);
    wait_done(0, 200, lat);
    check("t4_timeout_latency", lat, 65);
    check("t4_err0", err0, 1);
    check("t4_rdata0", rdata0, 8'h00);
    step();
    req0 = 0; slave_dly = 3; req1 = 1; rh_wl1 = 1; addr1 = 16'h0055;
    wait_exec(5, lat);
    check("t4_next_grant", grant, 1);
    wait_done(1, 50, lat);
    check("t4_next_latency", lat, 4);
    check("t4_next_err1", err1, 0);
    step();
    req1 = 0;

    // 5: field stability and requester drop while granted
    slave_dly = 30;
    step();
    req0 = 1; addr0 = 16'h1234; wdata0 = 8'h77; rh_wl0 = 0;
    wait_exec(5, lat);
    repeat (5) step();
    addr0 = 16'hFFFF; req0 = 0;
    stable = 1; got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (i2c_addr !== 16'h1234) stable = 0;
      if (done0) got = 1;
    end
    check("t5_addr_stable", stable, 1);
    check("t5_done0_pulsed", got, 1);

    // 6: reset in the middle of WAIT, late i2c_done in idle
    slave_dly = 20;
    step();
    req1 = 1; addr1 = 16'hABCD; wdata1 = 8'h3C; rh_wl1 = 0;
    wait_exec(5, lat);
    repeat (5) step();
    rst = 1; req1 = 0;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_ctrl", {i2c_exec, busy, grant, done0, done1, err0, err1}, 0);
    check("t6_rst_fields", {i2c_addr, i2c_data_w, i2c_rh_wl, i2c_bit_ctrl}, 0);
    check("t6_rst_rdata", {rdata0, rdata1}, 0);
    step();
    rst = 0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done0 || done1 || busy || i2c_exec) bad = 1;
    end
    check("t6_late_done_ignored", bad, 0);

    // Randomized traffic
    slave_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      d0 = done0; d1 = done1;
      step();
      if (req0) begin
        if (d0 && $urandom_range(0, 1) == 1) req0 = 0;
        else if ($urandom_range(0, 63) == 0) req0 = 0;
        else if ($urandom_range(0, 3) == 0) begin
          addr0 = 16'($urandom); wdata0 = 8'($urandom);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        req0 = 1; addr0 = 16'($urandom); wdata0 = 8'($urandom);
        rh_wl0 = 1'($urandom); bit_ctrl0 = 1'($urandom);
      end
      if (req1) begin
        if (d1 && $urandom_range(0, 1) == 1) req1 = 0;
        else if ($urandom_range(0, 63) == 0) req1 = 0;
        else if ($urandom_range(0, 3) == 0) begin
          addr1 = 16'($urandom); wdata1 = 8'($urandom);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        req1 = 1; addr1 = 16'($urandom); wdata1 = 8'($urandom);
        rh_wl1 = 1'($urandom); bit_ctrl1 = 1'($urandom);
      end
    end
    req0 = 0; req1 = 0;
    repeat (100) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
- Shares one i2c_dri instance between two command sources.
- Port 0 is the WM8978 power-up register sequencer (i2c_reg_cfg). Port 1 is the runtime control path (volume/mute writes, status reads).
- Grants one transaction at a time and issues a single-cycle i2c_exec with latched fields. Waits for i2c_done, then routes done, read data and timeout error back to the granted requester.
- Runs in the i2c_dri operating-clock domain (dri_clk).

Parameters:
- TIMEOUT_CYC, 20'd100_000, dri_clk cycles allowed between i2c_exec and i2c_done before abort.
- ADDR_W, 16, width of the I2C word-address field passed to i2c_dri.

Ports:
- clk  in  1  I2C operating clock (i2c_dri dri_clk); single clock domain.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  port-0 request; held high until done0.
- addr0  in  ADDR_W  port-0 word address.
- wdata0  in  8  port-0 write data.
- rh_wl0  in  1  port-0 direction, 1=read, 0=write.
- bit_ctrl0  in  1  port-0 address width, 1=16b, 0=8b.
- done0  out  1  port-0 completion pulse.
- rdata0  out  8  port-0 read data, valid with done0.
- err0  out  1  port-0 timeout flag, valid with done0.
- req1, addr1, wdata1, rh_wl1, bit_ctrl1, done1, rdata1, err1: same as port 0, for port 1.
- i2c_exec  out  1  single-cycle start to i2c_dri.
- i2c_addr  out  ADDR_W  latched address.
- i2c_data_w  out  8  latched write data.
- i2c_rh_wl  out  1  latched direction.
- i2c_bit_ctrl  out  1  latched address width.
- i2c_data_r  in  8  read data from i2c_dri.
- i2c_done  in  1  completion pulse from i2c_dri.
- busy  out  1  high whenever state is not IDLE.
- grant  out  1  index of the current or last granted port.

Behaviour:
- Reset: state=IDLE. All outputs 0: i2c_exec, i2c_addr, i2c_data_w, i2c_rh_wl, i2c_bit_ctrl, done*, rdata*, err*, busy, grant. Timeout counter 0. Round-robin pointer set to port 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select the winner and latch its addr/wdata/rh_wl/bit_ctrl into the i2c_* outputs. Set grant, go to ISSUE.
  - i2c_done seen in IDLE is ignored.
- ISSUE:
  - i2c_exec=1 for exactly this one cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On i2c_done: capture i2c_data_r, err=0, go to RESP.
  - If the counter reaches TIMEOUT_CYC-1 first: err=1, rdata=8'h00, go to RESP.
  - If i2c_done and the timeout occur in the same cycle, i2c_done wins (err=0).
- RESP:
  - done<grant>=1 for one cycle, with rdata<grant> and err<grant> driven.
  - rdata/err hold their values until the next RESP on that port.
  - Go to IDLE.
- Latency:
  - req rising in IDLE -> i2c_exec 2 cycles later (cycle N sample, N+1 exec).
  - i2c_done at cycle M -> done<grant> at M+1.
  - Minimum gap between back-to-back execs: 4 cycles.
- Latched fields are stable from ISSUE through RESP. Requester input changes after grant have no effect.
- A requester dropping req while granted does not abort the transaction; done is still pulsed.
- A requester must not re-raise req in the cycle done is pulsed. req still high in the cycle after done is treated as a new request.
- Non-granted requests wait indefinitely. No request is ever dropped.
- rst asserted mid-transaction returns everything to reset values on the next edge, with no done pulse. i2c_dri shares the same reset.

Optional Feature:
- Macro: I2C_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On simultaneous req0 and req1, the port not granted last wins.
  - The pointer updates at each grant.
- Undefined: fixed priority, port 0 always wins. Port 1 is served only when req0 is low in IDLE. This guarantees the configuration sequence finishes before runtime writes.

Test Plan:
1. Single write: req0=1, addr0=16'h000B, wdata0=8'hFF, rh_wl0=0 -> i2c_exec pulse 2 cycles later with i2c_addr=16'h000B, i2c_data_w=8'hFF. Model i2c_done after 40 cycles -> done0 1 cycle later, err0=0, busy low the following cycle.
2. Read: req1=1, rh_wl1=1, addr1=16'h0034; model returns i2c_data_r=8'h5A -> done1 with rdata1=8'h5A, err1=0; done0 stays 0.
3. Contention: req0 and req1 raised in the same cycle, both held for 3 transactions each.
   - Without I2C_ARB_RR_EN: grant order 0,0,0,1,1,1.
   - With I2C_ARB_RR_EN: 0,1,0,1,0,1.
4. Timeout: TIMEOUT_CYC=20'd64, model never asserts i2c_done -> done0 with err0=1, rdata0=8'h00, 65 cycles after i2c_exec. The next req1 is then served normally.
5. Field stability: after grant, change addr0 to 16'hFFFF during WAIT -> i2c_addr keeps its original value until RESP. Also drop req0 mid-WAIT -> done0 still pulses.
6. Reset mid-op: assert rst 5 cycles into WAIT -> next cycle all outputs 0, no done pulse. A late i2c_done in IDLE produces no response.
